// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//   Operand stager for an NxN systolic_array. Holds one A and one B matrix,
//   and on start clears the array accumulators, then streams A rows into
//   in_left and B columns into in_top with a diagonal skew. It drives
//   acc_rst/acc_en/shift_en so the array ends up holding C = A*B, and pulses
//   done once acc_out is final.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset (operand storage kept)
//   wr_en     in   operand row write strobe, honoured only while idle
//   wr_sel    in   0 = write A row, 1 = write B row
//   wr_addr   in   row index
//   wr_data   in   row data, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   start     in   begin a multiply, honoured only while idle
//   busy      out  sequence in progress
//   done      out  one-cycle pulse, result valid on the array's acc_out
//   in_left   out  per-row A operand to the array
//   in_top    out  per-column B operand to the array
//   acc_rst   out  array accumulator clear
//   acc_en    out  array accumulate enable
//   shift_en  out  array operand shift enable
// ---------------------------------------------------------------------------
module systolic_feeder #(
  parameter int MATRIX_SIZE  = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic                              wr_sel,
  input  logic [$clog2(MATRIX_SIZE)-1:0]    wr_addr,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] wr_data,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [DATA_WIDTH-1:0]             in_left [MATRIX_SIZE],
  output logic [DATA_WIDTH-1:0]             in_top  [MATRIX_SIZE],
  output logic                              acc_rst,
  output logic                              acc_en,
  output logic                              shift_en
);

  localparam int CNT_W = $clog2(3*MATRIX_SIZE - 2 + FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(3*MATRIX_SIZE - 3);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DONE_LAST   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;

  logic [DATA_WIDTH-1:0] a_mem_q [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_WIDTH-1:0] a_mem_d [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_WIDTH-1:0] b_mem_q [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_WIDTH-1:0] b_mem_d [MATRIX_SIZE][MATRIX_SIZE];

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  acc_rst_q, acc_rst_d;
  logic                  acc_en_q, acc_en_d;
  logic                  shift_en_q, shift_en_d;
  logic [DATA_WIDTH-1:0] in_left_q [MATRIX_SIZE];
  logic [DATA_WIDTH-1:0] in_left_d [MATRIX_SIZE];
  logic [DATA_WIDTH-1:0] in_top_q  [MATRIX_SIZE];
  logic [DATA_WIDTH-1:0] in_top_d  [MATRIX_SIZE];

  // Next-state and beat counter. DONE is held for two cycles: the first lets
  // the last flush accumulate land on acc_out, the second pulses done.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE: begin
        t_d = '0;
        if (start) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_STREAM;
        t_d     = '0;
      end
      ST_STREAM: begin
        if (t_q == STREAM_LAST) begin
          t_d = '0;
          if (FLUSH_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FLUSH;
          end
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (t_q == FLUSH_LAST) begin
          t_d     = '0;
          state_d = ST_DONE;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (t_q == DONE_LAST) begin
          t_d     = '0;
          state_d = ST_IDLE;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Operand storage update: one row per cycle, only while idle.
  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if ((state_q == ST_IDLE) && wr_en) begin
      for (int j = 0; j < MATRIX_SIZE; j++) begin
        if (wr_sel) begin
          b_mem_d[wr_addr][j] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          a_mem_d[wr_addr][j] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end else begin
      a_mem_d = a_mem_q;
    end
  end

  // Output values for the next cycle. Skew: row i / column j carries element
  // k on beat t = i + k (resp. j + k); every other beat is zero-filled.
  always_comb begin
    busy_d     = (state_q != ST_IDLE);
    done_d     = (state_q == ST_DONE) && (t_q == DONE_LAST);
    acc_rst_d  = (state_q == ST_CLEAR);
    acc_en_d   = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
    shift_en_d = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      in_left_d[i] = '0;
      in_top_d[i]  = '0;
    end
    if (state_q == ST_STREAM) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        for (int k = 0; k < MATRIX_SIZE; k++) begin
          if (t_q == CNT_W'(i + k)) begin
            in_left_d[i] = a_mem_q[i][k];
            in_top_d[i]  = b_mem_q[k][i];
          end else begin
            in_left_d[i] = in_left_d[i];
          end
        end
      end
    end else begin
      busy_d = busy_d;
    end
  end

  // Control state and registered outputs; reset aborts immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_rst_q  <= 1'b0;
      acc_en_q   <= 1'b0;
      shift_en_q <= 1'b0;
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        in_left_q[i] <= '0;
        in_top_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_rst_q  <= acc_rst_d;
      acc_en_q   <= acc_en_d;
      shift_en_q <= shift_en_d;
      in_left_q  <= in_left_d;
      in_top_q   <= in_top_d;
    end
  end

  // Operand storage; deliberately survives reset.
  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign acc_rst  = acc_rst_q;
  assign acc_en   = acc_en_q;
  assign shift_en = shift_en_q;
  assign in_left  = in_left_q;
  assign in_top   = in_top_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
//   Directed bench for systolic_feeder (N=4, DW=8, FLUSH_CYCLES=1). A small
//   behavioural systolic array consumes the feeder outputs so the final
//   C = A*B can be compared with the product of the loaded matrices.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int F  = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_en;
  logic                   wr_sel;
  logic [$clog2(N)-1:0]   wr_addr;
  logic [N*DW-1:0]        wr_data;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [DW-1:0]          in_left [N];
  logic [DW-1:0]          in_top  [N];
  logic                   acc_rst;
  logic                   acc_en;
  logic                   shift_en;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [DW-1:0] a_exp [N][N];
  logic [DW-1:0] b_exp [N][N];

  // behavioural array model
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  logic [DW-1:0] a_in [N][N];
  logic [DW-1:0] b_in [N][N];
  logic [31:0]   macc [N][N];

  systolic_feeder #(
    .MATRIX_SIZE (N),
    .DATA_WIDTH  (DW),
    .FLUSH_CYCLES(F)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .in_left (in_left),
    .in_top  (in_top),
    .acc_rst (acc_rst),
    .acc_en  (acc_en),
    .shift_en(shift_en)
  );

  always #5 clk = ~clk;

  // PE operand inputs: left edge / top edge come from the feeder
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = in_left[i];
      for (int j = 1; j < N; j++) a_in[i][j] = ma[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      b_in[0][j] = in_top[j];
      for (int i = 1; i < N; i++) b_in[i][j] = mb[i-1][j];
    end
  end

  // PE registers and accumulators (accumulators untouched by rst)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ma[i][j] <= '0;
          mb[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (shift_en) begin
            ma[i][j] <= a_in[i][j];
            mb[i][j] <= b_in[i][j];
          end
          if (acc_rst) macc[i][j] <= 32'd0;
          else if (acc_en) macc[i][j] <= macc[i][j] + 32'(a_in[i][j]) * 32'(b_in[i][j]);
        end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] row4(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  task automatic write_row(input logic sel, input int addr, input logic [N*DW-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 2'(addr);
    wr_data = data;
    for (int j = 0; j < N; j++) begin
      if (sel) b_exp[addr][j] = data[j*DW +: DW];
      else     a_exp[addr][j] = data[j*DW +: DW];
    end
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_product(input string tag);
    logic [31:0] c;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c = 32'd0;
        for (int k = 0; k < N; k++) c = c + 32'(a_exp[i][k]) * 32'(b_exp[k][j]);
        check_val($sformatf("%s_c%0d%0d", tag, i, j), macc[i][j], c);
      end
  endtask

  // mode 0: plain run; 1: start + A write mid-stream; 2: reset at beat 5
  task automatic run_seq(input string tag, input int mode, input bit wr_with_start,
                         input logic [N*DW-1:0] row_data);
    int en_cnt;
    int done_cnt;
    logic [DW-1:0] exp_l;
    logic [DW-1:0] exp_t;
    en_cnt = 0;
    start  = 1'b1;
    if (wr_with_start) begin
      wr_en   = 1'b1;
      wr_sel  = 1'b0;
      wr_addr = 2'd2;
      wr_data = row_data;
      for (int j = 0; j < N; j++) a_exp[2][j] = row_data[j*DW +: DW];
    end
    step();                          // edge k: start sampled
    start = 1'b0;
    wr_en = 1'b0;
    step();                          // k+1: clear
    check_val({tag, "_acc_rst"}, acc_rst, 1);
    check_val({tag, "_clr_acc_en"}, acc_en, 0);
    check_val({tag, "_clr_shift"}, shift_en, 0);
    check_val({tag, "_clr_busy"}, busy, 1);
    for (int t = 0; t < 3*N-2; t++) begin
      step();                        // k+2+t: beat t
      if (mode == 1 && t == 4) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (acc_en) en_cnt++;
      check_val($sformatf("%s_t%0d_ctl", tag, t), {acc_rst, acc_en, shift_en, done}, 4'b0110);
      for (int i = 0; i < N; i++) begin
        exp_l = '0;
        exp_t = '0;
        if (t >= i && t - i < N) begin
          exp_l = a_exp[i][t-i];
          exp_t = b_exp[t-i][i];
        end
        check_val($sformatf("%s_left%0d_t%0d", tag, i, t), in_left[i], exp_l);
        check_val($sformatf("%s_top%0d_t%0d", tag, i, t), in_top[i], exp_t);
      end
      if (mode == 1 && t == 3) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = 2'd3;
        wr_data = 32'hFFFF_FFFF;
      end
      if (mode == 2 && t == 5) begin
        rst = 1'b1;
        #1;
        check_val({tag, "_abort_ctl"}, {busy, done, acc_rst, acc_en, shift_en}, 5'b00000);
        check_val({tag, "_abort_left2"}, in_left[2], 0);
        check_val({tag, "_abort_top2"}, in_top[2], 0);
        step();
        step();
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
          step();
          if (done) done_cnt++;
        end
        check_val({tag, "_abort_no_done"}, done_cnt, 0);
        check_val({tag, "_abort_idle"}, busy, 0);
        return;
      end
    end
    for (int f = 0; f < F; f++) begin
      step();                        // flush
      if (acc_en) en_cnt++;
      check_val($sformatf("%s_flush%0d_ctl", tag, f), {acc_en, shift_en, done}, 3'b110);
      check_val($sformatf("%s_flush%0d_left0", tag, f), in_left[0], 0);
      check_val($sformatf("%s_flush%0d_top3", tag, f), in_top[3], 0);
    end
    step();                          // k+3N+F: settle cycle
    if (acc_en) en_cnt++;
    check_val({tag, "_settle_ctl"}, {busy, done, acc_en, shift_en}, 4'b1000);
    step();                          // k+3N+F+1: done
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_done_busy"}, busy, 1);
    check_val({tag, "_acc_en_cycles"}, en_cnt, 3*N-2+F);
    step();
    check_val({tag, "_done_pulse"}, done, 0);
    check_val({tag, "_idle_busy"}, busy, 0);
    check_product(tag);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    step();
    step();
    check_val("rst_ctl", {busy, done, acc_rst, acc_en, shift_en}, 5'b00000);
    check_val("rst_left0", in_left[0], 0);
    check_val("rst_top3", in_top[3], 0);
    rst = 1'b0;
    step();
    check_val("idle_busy", busy, 0);

    // 1: A = 1..16, B = identity
    for (int r = 0; r < N; r++) begin
      write_row(1'b0, r, row4(4*r+1, 4*r+2, 4*r+3, 4*r+4));
      write_row(1'b1, r, 32'd1 << (r*8));
    end
    run_seq("t1", 0, 1'b0, '0);
    check_val("t1_c30", macc[3][0], 13);
    check_val("t1_c33", macc[3][3], 16);

    // 2: A all 2, B all 3
    for (int r = 0; r < N; r++) begin
      write_row(1'b0, r, row4(2, 2, 2, 2));
      write_row(1'b1, r, row4(3, 3, 3, 3));
    end
    run_seq("t2", 0, 1'b0, '0);
    check_val("t2_c12", macc[1][2], 24);

    // 3 + 6: disturbance while busy, then immediate back-to-back run
    for (int r = 0; r < N; r++) begin
      write_row(1'b0, r, row4(4*r+1, 4*r+2, 4*r+3, 4*r+4));
      write_row(1'b1, r, 32'd1 << (r*8));
    end
    run_seq("t3", 1, 1'b0, '0);
    run_seq("t6", 0, 1'b0, '0);
    check_val("t6_c32", macc[3][2], 15);

    // 4: write A row 2 in the start cycle
    run_seq("t4", 0, 1'b1, row4(50, 60, 70, 80));
    check_val("t4_c21", macc[2][1], 60);

    // 5: reset mid-stream, then a clean run
    run_seq("t5a", 2, 1'b0, '0);
    run_seq("t5b", 0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
